// File: rtl/stopwatch_counter_if.sv
// Control and status bundle for the stopwatch counter; the datapath owns the slave side.
interface stopwatch_counter_if #(
    parameter int NUMBER_OF_DIGITS         = 4,
    parameter int NUMBER_OF_BITS_PER_DIGIT = 4
);
    localparam int W = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT;

    logic         enable;
    logic         up_down;
    logic         load;
    logic [W-1:0] load_value;
    logic         clear;
    logic         lap;
    logic [W-1:0] count;
    logic [W-1:0] display;
    logic         tick;
    logic         wrapped;
    logic         expired;
    logic         frozen;

    modport master (
        output enable, up_down, load, load_value, clear, lap,
        input  count, display, tick, wrapped, expired, frozen
    );

    modport slave (
        input  enable, up_down, load, load_value, clear, lap,
        output count, display, tick, wrapped, expired, frozen
    );
endinterface

// File: rtl/stopwatch_counter.sv
// N-digit mixed-radix up/down time counter with prescaler, preset load, lap freeze
// and countdown expiry. Per-digit arithmetic lives in stopwatch_counter_digit.
module stopwatch_counter_digit #(
    parameter int B    = 4,
    parameter int BASE = 10
) (
    input  logic [B-1:0] d_i,
    input  logic [B-1:0] ld_i,
    output logic         at_max_o,
    output logic         at_zero_o,
    output logic [B-1:0] up_o,
    output logic [B-1:0] dn_o,
    output logic [B-1:0] ld_o
);
    localparam logic [B-1:0] MAX = B'(BASE - 1);

    assign at_max_o  = (d_i == MAX);
    assign at_zero_o = (d_i == '0);
    assign up_o      = at_max_o  ? '0  : d_i + B'(1);
    assign dn_o      = at_zero_o ? MAX : d_i - B'(1);
    assign ld_o      = (ld_i > MAX) ? MAX : ld_i;
endmodule

module stopwatch_counter #(
    parameter int                          NUMBER_OF_DIGITS         = 4,
    parameter int                          NUMBER_OF_BITS_PER_DIGIT = 4,
    parameter logic [NUMBER_OF_DIGITS*8-1:0] DIGIT_BASES            = {8'd6, 8'd10, 8'd6, 8'd10},
    parameter int                          TICK_DIVISOR             = 100_000_000,
    parameter bit                          STOP_AT_ZERO             = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    stopwatch_counter_if.slave   bus
);
    localparam int N  = NUMBER_OF_DIGITS;
    localparam int B  = NUMBER_OF_BITS_PER_DIGIT;
    localparam int PW = (TICK_DIVISOR > 1) ? $clog2(TICK_DIVISOR) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIVISOR - 1);

    logic [N-1:0][B-1:0] cnt_q, cnt_d, lap_q, lap_d;
    logic [N-1:0][B-1:0] dig_up, dig_dn, cnt_ld, cnt_up, cnt_dn, ld_val;
    logic [N-1:0]        at_max, at_zero;
    logic [N:0]          inc_c, dec_c;
    logic [PW-1:0]       pre_q, pre_d;
    logic                tick_q, tick_d, wrap_q, wrap_d;
    logic                exp_q, exp_d, frz_q, frz_d;
    logic                all_max, all_zero;

    assign ld_val   = bus.load_value;
    assign inc_c[0] = 1'b1;
    assign dec_c[0] = 1'b1;

    // A digit moves only when every lower digit is at its roll-over point.
    for (genvar k = 0; k < N; k++) begin : g_dig
        stopwatch_counter_digit #(
            .B    (B),
            .BASE (int'(DIGIT_BASES[8*k +: 8]))
        ) u_dig (
            .d_i       (cnt_q[k]),
            .ld_i      (ld_val[k]),
            .at_max_o  (at_max[k]),
            .at_zero_o (at_zero[k]),
            .up_o      (dig_up[k]),
            .dn_o      (dig_dn[k]),
            .ld_o      (cnt_ld[k])
        );
        assign inc_c[k+1] = inc_c[k] & at_max[k];
        assign dec_c[k+1] = dec_c[k] & at_zero[k];
        assign cnt_up[k]  = inc_c[k] ? dig_up[k] : cnt_q[k];
        assign cnt_dn[k]  = dec_c[k] ? dig_dn[k] : cnt_q[k];
    end

    assign all_max  = inc_c[N];
    assign all_zero = dec_c[N];

    always_comb begin
        cnt_d  = cnt_q;
        lap_d  = lap_q;
        pre_d  = pre_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        exp_d  = exp_q;
        frz_d  = frz_q;

        // Snapshot uses the pre-step count even when a step lands this cycle.
        if (bus.lap) begin
            if (!frz_q) begin
                lap_d = cnt_q;
                frz_d = 1'b1;
            end else begin
                frz_d = 1'b0;
            end
        end

        if (bus.clear) begin
            cnt_d = '0;
            pre_d = '0;
            exp_d = 1'b0;
            frz_d = 1'b0;
        end else if (bus.load) begin
            cnt_d = cnt_ld;
            pre_d = '0;
            exp_d = 1'b0;
        end else if (bus.enable) begin
            if (pre_q == PRE_MAX) begin
                pre_d = '0;
                if (bus.up_down) begin
                    cnt_d  = cnt_up;
                    tick_d = 1'b1;
                    wrap_d = all_max;
                    exp_d  = 1'b0;
                end else if (STOP_AT_ZERO && (all_zero || exp_q)) begin
                    exp_d = 1'b1;
                end else begin
                    cnt_d  = cnt_dn;
                    tick_d = 1'b1;
                    wrap_d = all_zero;
                end
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            lap_q  <= '0;
            pre_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            exp_q  <= 1'b0;
            frz_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lap_q  <= lap_d;
            pre_q  <= pre_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
            exp_q  <= exp_d;
            frz_q  <= frz_d;
        end
    end

    assign bus.count   = cnt_q;
    assign bus.display = frz_q ? lap_q : cnt_q;
    assign bus.tick    = tick_q;
    assign bus.wrapped = wrap_q;
    assign bus.expired = exp_q;
    assign bus.frozen  = frz_q;
endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: mm:ss radix chain, TICK_DIVISOR=4, with a
// second instance built with STOP_AT_ZERO=0 for the countdown wrap case.
module tb_stopwatch_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    stopwatch_counter_if #(.NUMBER_OF_DIGITS(4), .NUMBER_OF_BITS_PER_DIGIT(4)) bus ();
    stopwatch_counter_if #(.NUMBER_OF_DIGITS(4), .NUMBER_OF_BITS_PER_DIGIT(4)) bus2 ();

    stopwatch_counter #(
        .NUMBER_OF_DIGITS(4), .NUMBER_OF_BITS_PER_DIGIT(4),
        .DIGIT_BASES({8'd6, 8'd10, 8'd6, 8'd10}), .TICK_DIVISOR(4), .STOP_AT_ZERO(1'b1)
    ) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    stopwatch_counter #(
        .NUMBER_OF_DIGITS(4), .NUMBER_OF_BITS_PER_DIGIT(4),
        .DIGIT_BASES({8'd6, 8'd10, 8'd6, 8'd10}), .TICK_DIVISOR(4), .STOP_AT_ZERO(1'b0)
    ) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.load       = 1'b1;
        bus.load_value = v;
        cyc(1);
        bus.load       = 1'b0;
    endtask

    task automatic do_lap();
        bus.lap = 1'b1;
        cyc(1);
        bus.lap = 1'b0;
    endtask

    initial begin
        bus.enable = 0; bus.up_down = 1; bus.load = 0; bus.load_value = '0;
        bus.clear = 0;  bus.lap = 0;
        bus2.enable = 0; bus2.up_down = 0; bus2.load = 0; bus2.load_value = '0;
        bus2.clear = 0;  bus2.lap = 0;

        cyc(2);
        chk("rst_count",   bus.count,   32'h0);
        chk("rst_display", bus.display, 32'h0);
        chk("rst_flags",   {bus.tick, bus.wrapped, bus.expired, bus.frozen}, 32'h0);
        rst = 1'b1;
        cyc(3);
        chk("paused_hold", bus.count, 32'h0);

        // Up count with carry into tens and minutes
        bus.enable = 1; bus.up_down = 1;
        cyc(3);
        chk("no_tick_early", bus.tick, 32'h0);
        cyc(1);
        chk("first_tick", bus.tick, 32'h1);
        chk("first_step", bus.count, 32'h0001);
        cyc(36);
        chk("up_40cyc", bus.count, 32'h0010);
        cyc(1);
        chk("tick_one_cycle", bus.tick, 32'h0);
        cyc(195);
        chk("up_59", bus.count, 32'h0059);
        cyc(4);
        chk("carry_min", bus.count, 32'h0100);
        chk("no_wrap_carry", bus.wrapped, 32'h0);

        // Full wrap
        do_load(16'h5959);
        chk("load_5959", bus.count, 32'h5959);
        cyc(3);
        chk("load_restart", bus.count, 32'h5959);
        cyc(1);
        chk("full_wrap", bus.count, 32'h0000);
        chk("wrap_pulse", bus.wrapped, 32'h1);
        cyc(1);
        chk("wrap_one_cycle", bus.wrapped, 32'h0);

        // Countdown expiry
        bus.up_down = 0;
        do_load(16'h0002);
        cyc(4);
        chk("down_1", bus.count, 32'h0001);
        cyc(4);
        chk("down_0", bus.count, 32'h0000);
        chk("down_0_tick", bus.tick, 32'h1);
        chk("not_expired_yet", bus.expired, 32'h0);
        cyc(4);
        chk("expired_set", bus.expired, 32'h1);
        chk("expired_no_tick", bus.tick, 32'h0);
        chk("expired_hold", bus.count, 32'h0000);
        cyc(4);
        chk("expired_stays", bus.expired, 32'h1);
        do_load(16'h0005);
        chk("load_clr_exp", bus.expired, 32'h0);
        chk("load_5", bus.count, 32'h0005);

        // Countdown wrap on the non-stopping instance
        bus2.enable = 1;
        cyc(4);
        chk("dwrap_count", bus2.count, 32'h5959);
        chk("dwrap_pulse", bus2.wrapped, 32'h1);
        chk("dwrap_exp", bus2.expired, 32'h0);
        bus2.enable = 0;

        // Clamp and priority
        do_load(16'hFFFF);
        chk("clamp_ffff", bus.count, 32'h5959);
        do_load(16'h3A7C);
        chk("clamp_mixed", bus.count, 32'h3959);
        bus.clear = 1; bus.load = 1; bus.load_value = 16'h1234;
        cyc(1);
        bus.clear = 0; bus.load = 0;
        chk("clear_over_load", bus.count, 32'h0000);
        bus.up_down = 1;
        cyc(3);
        bus.clear = 1;
        cyc(1);
        bus.clear = 0;
        chk("clear_on_tick", bus.tick, 32'h0);
        chk("clear_on_tick_cnt", bus.count, 32'h0000);
        cyc(3);
        chk("post_clear_wait", bus.tick, 32'h0);
        cyc(1);
        chk("post_clear_step", bus.count, 32'h0001);

        // Lap freeze
        do_load(16'h0012);
        do_lap();
        chk("lap_frozen", bus.frozen, 32'h1);
        chk("lap_disp", bus.display, 32'h0012);
        cyc(31);
        chk("lap_count_runs", bus.count, 32'h0020);
        chk("lap_disp_held", bus.display, 32'h0012);
        do_lap();
        chk("unfreeze", bus.frozen, 32'h0);
        chk("unfreeze_disp", bus.display, 32'h0020);
        cyc(2);
        do_lap();
        chk("lap_on_step_cnt", bus.count, 32'h0021);
        chk("lap_on_step_disp", bus.display, 32'h0020);

        // Asynchronous reset mid-count, between edges
        #2 rst = 1'b0;
        #1;
        chk("async_count",   bus.count,   32'h0);
        chk("async_display", bus.display, 32'h0);
        chk("async_flags",   {bus.tick, bus.wrapped, bus.expired, bus.frozen}, 32'h0);
        chk("async_dut2",    bus2.count,  32'h0);
        rst = 1'b1;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
